// File: rtl/uart_tx_frame_ctrl.sv
// UART transmitter: one-entry holding buffer, frame FSM, serializer and parity generator.
// Accept takes one CLK; a frame starts on the next TICK; Data_valid is ignored while ready=0.
module uart_tx_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  TICK,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  ready,
   output logic                  frame_done
);
   localparam int            CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state, nxt_state;
   logic [CW-1:0]         cnt, nxt_cnt;
   logic [DATA_WIDTH-1:0] shreg, nxt_shreg, shifted;
   logic                  cur_bit;
   logic                  tx_q, nxt_tx;
   logic                  stop_sec, nxt_stop_sec;
   logic                  load, done, done_q;

   logic                  hold_full;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_par_en, hold_par_typ, hold_stop2;

   logic                  par_en_q, stop2_q, parity_q;

   if (MSB_FIRST) begin : g_msb
      assign cur_bit = shreg[DATA_WIDTH-1];
      assign shifted = {shreg[DATA_WIDTH-2:0], 1'b0};
   end else begin : g_lsb
      assign cur_bit = shreg[0];
      assign shifted = {1'b0, shreg[DATA_WIDTH-1:1]};
   end

   assign TX_OUT     = tx_q;
   assign busy       = (state != IDLE);
   assign ready      = ~hold_full;
   assign frame_done = done_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hold_full    <= 1'b0;
         hold_data    <= '0;
         hold_par_en  <= 1'b0;
         hold_par_typ <= 1'b0;
         hold_stop2   <= 1'b0;
      end else if (load) begin
         hold_full <= 1'b0;
      end else if (Data_valid && !hold_full) begin
         hold_full    <= 1'b1;
         hold_data    <= P_DATA;
         hold_par_en  <= PAR_EN;
         hold_par_typ <= PAR_TYP;
         hold_stop2   <= STOP2;
      end
   end

   // Everything except the illegal-state recovery only moves on TICK edges.
   always_comb begin
      nxt_state    = state;
      nxt_cnt      = cnt;
      nxt_shreg    = shreg;
      nxt_tx       = tx_q;
      nxt_stop_sec = stop_sec;
      load         = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (TICK) begin
               nxt_tx = 1'b1;
               if (hold_full) begin
                  load      = 1'b1;
                  nxt_shreg = hold_data;
                  nxt_state = START;
                  nxt_tx    = 1'b0;
               end
            end
         end
         START: begin
            if (TICK) begin
               nxt_state = DATA;
               nxt_tx    = cur_bit;
               nxt_shreg = shifted;
               nxt_cnt   = '0;
            end
         end
         DATA: begin
            if (TICK) begin
               if (cnt != LAST_BIT) begin
                  nxt_tx    = cur_bit;
                  nxt_shreg = shifted;
                  nxt_cnt   = cnt + CW'(1);
               end else if (par_en_q) begin
                  nxt_state = PARITY;
                  nxt_tx    = parity_q;
               end else begin
                  nxt_state    = STOP;
                  nxt_tx       = 1'b1;
                  nxt_stop_sec = 1'b0;
               end
            end
         end
         PARITY: begin
            if (TICK) begin
               nxt_state    = STOP;
               nxt_tx       = 1'b1;
               nxt_stop_sec = 1'b0;
            end
         end
         STOP: begin
            if (TICK) begin
               if (stop2_q && !stop_sec) begin
                  nxt_stop_sec = 1'b1;
               end else begin
                  done         = 1'b1;
                  nxt_stop_sec = 1'b0;
                  // A waiting frame starts straight away, with no idle bit in between.
                  if (hold_full) begin
                     load      = 1'b1;
                     nxt_shreg = hold_data;
                     nxt_state = START;
                     nxt_tx    = 1'b0;
                  end else begin
                     nxt_state = IDLE;
                     nxt_tx    = 1'b1;
                  end
               end
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_tx    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
         stop_sec <= 1'b0;
         done_q   <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         shreg    <= nxt_shreg;
         tx_q     <= nxt_tx;
         stop_sec <= nxt_stop_sec;
         done_q   <= done;
         if (load) begin
            par_en_q <= hold_par_en;
            stop2_q  <= hold_stop2;
            parity_q <= (^hold_data) ^ hold_par_typ;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: 8-bit LSB-first and 5-bit MSB-first instances driven in lockstep,
// line levels compared against a per-tick bit-queue model plus fixed expected frame strings.
module tb_uart_tx_frame_ctrl;
   logic       CLK = 1'b0;
   logic       RST, TICK, Data_valid, PAR_EN, PAR_TYP, STOP2;
   logic [7:0] p_data8;
   logic [4:0] p_data5;
   logic       tx8, busy8, ready8, done8;
   logic       tx5, busy5, ready5, done5;

   assign p_data5 = p_data8[4:0];

   uart_tx_frame_ctrl #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
      .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(p_data8), .Data_valid(Data_valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .TX_OUT(tx8), .busy(busy8), .ready(ready8), .frame_done(done8));

   uart_tx_frame_ctrl #(.DATA_WIDTH(5), .MSB_FIRST(1'b1)) dut5 (
      .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(p_data5), .Data_valid(Data_valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .TX_OUT(tx5), .busy(busy5), .ready(ready5), .frame_done(done5));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] d;
      bit         pe, pt, s2;
      string      e8, e5, nm;
   } vec_t;

   vec_t  tbl[6];
   int    checks = 0, errors = 0;
   int    tick_per = 4, tcnt = 0;
   string cap[2];
   int    fd[2];
   int    nbusy8 = 0, busy_win = 0;

   // Reference model: each accepted frame is a string of line levels, one per TICK.
   string m_hold[2], m_line[2];
   bit    m_hold_full[2], m_in[2], m_tx[2], m_done[2];
   int    m_pos[2], m_acc[2];

   function automatic string app(input string s, input logic v);
      string b;
      b = (v === 1'b1) ? "1" : "0";
      return {s, b};
   endfunction

   function automatic string frame_bits(input int w, input bit msb, input logic [7:0] d,
                                        input bit pe, input bit pt, input bit s2);
      string s;
      int    ones, idx;
      s = "0";
      ones = 0;
      for (int i = 0; i < w; i++) begin
         idx  = msb ? (w - 1 - i) : i;
         s    = app(s, d[idx]);
         ones += int'(d[idx]);
      end
      if (pe) s = app(s, ((ones % 2) == 1) ^ pt);
      s = app(s, 1'b1);
      if (s2) s = app(s, 1'b1);
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_hold[k] = ""; m_line[k] = ""; m_pos[k] = 0;
         m_hold_full[k] = 1'b0; m_in[k] = 1'b0; m_tx[k] = 1'b1; m_done[k] = 1'b0;
      end
   endtask

   task automatic model_edge(input bit t);
      bit pre_full, ended;
      if (RST !== 1'b1) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         pre_full  = m_hold_full[k];
         m_done[k] = 1'b0;
         if (t) begin
            ended = m_in[k] && (m_pos[k] >= m_line[k].len());
            if (m_pos[k] >= m_line[k].len() && pre_full) begin
               m_line[k] = m_hold[k];
               m_pos[k] = 0;
               m_hold_full[k] = 1'b0;
            end
            m_done[k] = ended;
            if (m_pos[k] < m_line[k].len()) begin
               m_tx[k] = (m_line[k].getc(m_pos[k]) == "1");
               m_pos[k]++;
               m_in[k] = 1'b1;
            end else begin
               m_tx[k] = 1'b1;
               m_in[k] = 1'b0;
            end
         end
         if (Data_valid === 1'b1 && !pre_full) begin
            m_hold[k] = frame_bits((k == 0) ? 8 : 5, k == 1, p_data8, PAR_EN, PAR_TYP, STOP2);
            m_hold_full[k] = 1'b1;
            m_acc[k]++;
         end
      end
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic step();
      bit t;
      @(posedge CLK);
      t = TICK;
      model_edge(t);
      @(negedge CLK);
      chk("tx8", tx8, m_tx[0]);
      chk("busy8", busy8, m_in[0]);
      chk("ready8", ready8, !m_hold_full[0]);
      chk("done8", done8, m_done[0]);
      chk("tx5", tx5, m_tx[1]);
      chk("busy5", busy5, m_in[1]);
      chk("ready5", ready5, !m_hold_full[1]);
      chk("done5", done5, m_done[1]);
      if (t) begin
         cap[0] = app(cap[0], tx8);
         cap[1] = app(cap[1], tx5);
      end
      if (done8 === 1'b1) fd[0]++;
      if (done5 === 1'b1) fd[1]++;
      if (busy8 !== 1'b1 && cap[0].len() > 0 && cap[0].len() < busy_win) nbusy8++;
      tcnt++;
      if (tcnt >= tick_per) tcnt = 0;
      TICK = (tcnt == 0);
   endtask

   task automatic clear_cap();
      cap[0] = ""; cap[1] = ""; fd[0] = 0; fd[1] = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_in[0] || m_in[1] || m_hold_full[0] || m_hold_full[1]) && n < 2000) begin
         step();
         n++;
      end
      if (m_in[0] || m_in[1] || m_hold_full[0] || m_hold_full[1]) timeout("wait_idle");
   endtask

   task automatic wait_load();
      int n = 0;
      while (!(m_in[0] && !m_hold_full[0] && m_in[1] && !m_hold_full[1]) && n < 500) begin
         step();
         n++;
      end
      if (!(m_in[0] && !m_hold_full[0])) timeout("wait_load");
   endtask

   function automatic string pad(input string s, input int n);
      string r = s;
      while (r.len() < n) r = app(r, 1'b1);
      return r;
   endfunction

   task automatic cmp_capture(input string name, input string e8, input string e5);
      int n, k;
      n = ((e8.len() > e5.len()) ? e8.len() : e5.len()) + 2;
      k = 0;
      while (cap[0].len() < n && k < 2000) begin
         step();
         k++;
      end
      if (cap[0].len() < n) timeout({name, "_capture"});
      else begin
         chk_str({name, "_line8"}, cap[0].substr(0, n - 1), pad(e8, n));
         chk_str({name, "_line5"}, cap[1].substr(0, n - 1), pad(e5, n));
      end
   endtask

   task automatic set_vec(input int i, input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                          input string e8, input string e5, input string nm);
      tbl[i].d = d; tbl[i].pe = pe; tbl[i].pt = pt; tbl[i].s2 = s2;
      tbl[i].e8 = e8; tbl[i].e5 = e5; tbl[i].nm = nm;
   endtask

   task automatic run_frame(input vec_t v, input bit on_tick);
      int n = 0;
      wait_idle();
      if (on_tick) begin
         while (TICK !== 1'b1 && n < 20) begin
            step();
            n++;
         end
      end
      p_data8 = v.d; PAR_EN = v.pe; PAR_TYP = v.pt; STOP2 = v.s2;
      Data_valid = 1'b1;
      step();
      Data_valid = 1'b0;
      // Inputs change mid-frame; the frame in flight must not notice.
      p_data8 = ~v.d; PAR_EN = ~v.pe; PAR_TYP = ~v.pt; STOP2 = ~v.s2;
      clear_cap();
      cmp_capture(v.nm, v.e8, v.e5);
      chk_int({v.nm, "_fdone8"}, fd[0], 1);
      chk_int({v.nm, "_fdone5"}, fd[1], 1);
   endtask

   initial begin
      set_vec(0, 8'hA5, 0, 0, 0, "0101001011",  "0001011",  "basic_a5");
      set_vec(1, 8'hA5, 1, 0, 0, "01010010101", "00010101", "even_a5");
      set_vec(2, 8'hA5, 1, 1, 0, "01010010111", "00010111", "odd_a5");
      set_vec(3, 8'h07, 1, 0, 0, "01110000011", "00011111", "even_07");
      set_vec(4, 8'h01, 0, 0, 1, "01000000011", "00000111", "stop2_01");
      set_vec(5, 8'h01, 0, 0, 0, "0100000001",  "0000011",  "stop1_01");

      RST = 1'b0; TICK = 1'b0; Data_valid = 1'b0;
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; p_data8 = 8'h00;
      m_acc[0] = 0; m_acc[1] = 0;
      model_reset();
      clear_cap();
      repeat (3) step();
      chk("rst_tx8", tx8, 1'b1);
      chk("rst_busy8", busy8, 1'b0);
      chk("rst_ready8", ready8, 1'b1);
      chk("rst_done8", done8, 1'b0);
      RST = 1'b1;
      repeat (2) step();

      for (int i = 0; i < 6; i++) run_frame(tbl[i], (i % 2) == 1);

      // Back-to-back: second frame accepted right after the first load, no idle bit between.
      wait_idle();
      p_data8 = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
      Data_valid = 1'b1;
      step();
      Data_valid = 1'b0;
      clear_cap();
      busy_win = 21;
      nbusy8 = 0;
      wait_load();
      p_data8 = 8'h0F; STOP2 = 1'b0;
      Data_valid = 1'b1;
      step();
      Data_valid = 1'b0;
      cmp_capture("b2b", "010101010110111100001", "010101110011111");
      chk_int("b2b_busy_gap", nbusy8, 0);
      chk_int("b2b_fdone8", fd[0], 2);
      chk_int("b2b_fdone5", fd[1], 2);
      busy_win = 0;

      // Back-pressure: 0x11 shown only while full, 0x22 held until taken.
      wait_idle();
      p_data8 = 8'h33; PAR_EN = 1'b0; STOP2 = 1'b0;
      Data_valid = 1'b1;
      step();
      Data_valid = 1'b0;
      clear_cap();
      wait_load();
      p_data8 = 8'h44;
      Data_valid = 1'b1;
      step();
      p_data8 = 8'h11;
      repeat (3) step();
      p_data8 = 8'h22;
      begin
         int n = 0;
         while ((m_acc[0] < m_acc[1] - 0 + 0 && 1'b0) || ((m_hold_full[0] == 1'b0 || m_hold_full[1] == 1'b0 || !(m_pos[0] > 0 && m_line[0].len() > 0 && m_line[0].getc(1) == "0")) && n < 500)) begin
            step();
            n++;
         end
      end
      Data_valid = 1'b0;
      cmp_capture("bp", {"0110011001", "0001000101", "0010001001"}, {"0100111", "0001001", "0000101"});
      chk_int("bp_fdone8", fd[0], 3);
      chk_int("bp_fdone5", fd[1], 3);

      // Reset during data bit 3, then a clean frame.
      wait_idle();
      p_data8 = 8'h3C; PAR_EN = 1'b0; STOP2 = 1'b0;
      Data_valid = 1'b1;
      step();
      Data_valid = 1'b0;
      clear_cap();
      begin
         int n = 0;
         while (cap[0].len() < 5 && n < 200) begin
            step();
            n++;
         end
         if (cap[0].len() < 5) timeout("rst_mid_wait");
      end
      RST = 1'b0;
      #1;
      chk("midrst_tx8", tx8, 1'b1);
      chk("midrst_busy8", busy8, 1'b0);
      chk("midrst_ready8", ready8, 1'b1);
      chk("midrst_tx5", tx5, 1'b1);
      chk("midrst_busy5", busy5, 1'b0);
      chk("midrst_ready5", ready5, 1'b1);
      repeat (6) step();
      RST = 1'b1;
      step();
      begin
         vec_t v;
         v.d = 8'h3C; v.pe = 0; v.pt = 0; v.s2 = 0;
         v.e8 = "0001111001"; v.e5 = "0111001"; v.nm = "after_rst_3c";
         run_frame(v, 1'b0);
      end

      // Random traffic against the model, with varying baud period and one mid-stream reset.
      for (int seg = 0; seg < 6; seg++) begin
         tick_per = $urandom_range(2, 6);
         for (int c = 0; c < 400; c++) begin
            Data_valid = ($urandom_range(0, 2) == 0);
            p_data8 = 8'($urandom);
            PAR_EN = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
            STOP2 = 1'($urandom_range(0, 1));
            if (seg == 2 && c == 200) RST = 1'b0;
            if (seg == 2 && c == 203) RST = 1'b1;
            step();
         end
      end
      Data_valid = 1'b0;
      wait_idle();
      chk_int("final_accepts_match", m_acc[0] > 0 ? 1 : 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Parametrised UART transmit engine: frame FSM, serializer, parity generator and a one-entry holding buffer in one block.
- Emits start / data / optional parity / 1-or-2 stop bits on TX_OUT, paced by an external baud-rate TICK enable.
- Supports back-to-back frames with no idle gap between them.
- Sits between the TX data source and the UART pin; replaces the separate FSM + serializer + parity + mux arrangement.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB transmitted first.

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
TICK  input  1  baud enable, one CLK cycle wide; one bit period = interval between TICKs
P_DATA  input  DATA_WIDTH  parallel frame data
Data_valid  input  1  P_DATA/config valid; accepted only when ready=1
PAR_EN  input  1  1 = parity bit included in frame
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  0 = one stop bit, 1 = two stop bits
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  1 while state != IDLE
ready  output  1  holding buffer empty; a new frame can be accepted
frame_done  output  1  one-CLK pulse when the last stop bit ends

Behaviour:
- Reset (RST=0, asynchronous), taking effect immediately even mid-frame:
  - state = IDLE; TX_OUT = 1; busy = 0; ready = 1; frame_done = 0.
  - Holding buffer cleared; bit counter = 0.
- Accept:
  - On a CLK edge with Data_valid=1 and ready=1, capture P_DATA, PAR_EN, PAR_TYP and STOP2 into the holding buffer; ready becomes 0.
  - Data_valid is ignored while ready=0; no overwrite, no error.
- Load:
  - Holding buffer contents move into the shift register and per-frame config registers.
  - Holding buffer is freed (ready=1 next cycle).
  - Config is frozen per frame; input changes mid-frame have no effect.
- The state register, TX_OUT and the bit counter change only on CLK edges where TICK=1. All other edges hold, except accept and frame_done.
- FSM, evaluated on TICK edges:
  - IDLE: TX_OUT=1. If buffer full -> START (load), TX_OUT=0; otherwise stay.
  - START: -> DATA; TX_OUT = first data bit; counter = 0.
  - DATA: counter < DATA_WIDTH-1: shift, TX_OUT = next bit, counter+1. Counter = DATA_WIDTH-1: PAR_EN ? PARITY (TX_OUT=parity) : STOP (TX_OUT=1).
  - PARITY: -> STOP; TX_OUT = 1.
  - STOP: with STOP2=1, the first stop tick stays in STOP (second stop bit). On the final stop tick, frame_done=1 for that one cycle, then:
    - buffer full -> START (load), TX_OUT=0 directly, with no idle bit;
    - buffer empty -> IDLE, TX_OUT=1.
- Parity is computed over the frozen data word:
  - even: XOR of all data bits;
  - odd: inverted XOR of all data bits.
- Bit order: LSB first when MSB_FIRST=0, MSB first when MSB_FIRST=1.
- Frame length in TICKs = 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1).
- busy is 1 from the START entry edge until the edge returning to IDLE; it stays 1 across back-to-back frames.
- Simultaneous accept and load on one edge cannot occur, since ready=0 whenever a load happens. A new Data_valid on the cycle after a load is accepted.
- TICK asserted during reset has no effect. A TICK arriving in the same cycle as an accept does not start the frame; the frame starts on the next TICK.
- Unused/illegal state encodings -> IDLE with TX_OUT=1.

Test Plan:
1. Basic frame, LSB first: DATA_WIDTH=8, TICK every 4 CLKs, P_DATA=0xA5, PAR_EN=0, STOP2=0 -> TX_OUT per tick 0,1,0,1,0,0,1,0,1,1; frame_done pulses once; busy high for 10 ticks; ready=1 one cycle after load.
2. Parity: 0xA5 with PAR_EN=1 -> parity bit 0 (PAR_TYP=0) and 1 (PAR_TYP=1). 0x07 with PAR_TYP=0 -> parity bit 1. Frame is 11 ticks.
3. Back-to-back with two stop bits: send 0x55 (STOP2=1), then present 0x0F while busy -> 0x0F accepted after first load; after two stop bits TX_OUT goes straight to 0 (start); busy never drops; frame_done pulses twice total.
4. Back-pressure: Data_valid held high with 0x11 then 0x22 while ready=0 -> only the value present when ready=1 is captured; no frame is lost or duplicated.
5. Reset mid-frame: assert RST during data bit 3 -> TX_OUT=1, busy=0, ready=1 immediately. After release, a new 0x3C frame transmits correctly from START.
6. MSB_FIRST=1, DATA_WIDTH=5, P_DATA=5'b00001 -> data bits 0,0,0,0,1; total frame 7 ticks with one stop bit and no parity.
